// File: rtl/qsort_pkg.sv
// Shared definitions for the quicksort controller and the Lomuto partition engine.
package qsort_pkg;
    localparam int ARR_WIDTH_DEF = 4;
    localparam int DATA_W_DEF    = 4;
    localparam int TIMEOUT_DEF   = 16;

    typedef enum logic [2:0] {IDLE, POP, ISSUE, WAIT, CHECK, FINISH, FAIL} state_t;

    // Index width for n elements, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // A range entry packs {lo, hi}, each iw bits wide.
    function automatic int entry_w(input int iw);
        return 2 * iw;
    endfunction
endpackage

// File: rtl/qsort_range_stack.sv
// LIFO of {lo, hi} ranges: up to two pushes per cycle, one pop, combinational top.
module qsort_range_stack import qsort_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int EW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push_a,
    input  logic [EW-1:0] din_a,
    input  logic          push_b,
    input  logic [EW-1:0] din_b,
    input  logic          pop,
    output logic [EW-1:0] top,
    output logic          empty,
    output logic          full
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [SPW-1:0]           sp;

    assign empty = (sp == '0);
    // Full means the pushes requested this cycle do not fit; nothing is written then.
    assign full  = (int'(sp) + int'(push_a) + int'(push_b)) > DEPTH;

    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (SPW'(i + 1) == sp) top = mem[i];
    end

    // din_b lands just above din_a, so it is popped first; push_b only comes with push_a.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp  <= '0;
            mem <= '0;
        end else if (clear) begin
            sp <= '0;
        end else if (!full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_a && SPW'(i) == sp)           mem[i] <= din_a;
                if (push_b && SPW'(i) == sp + SPW'(1)) mem[i] <= din_b;
            end
            sp <= sp + SPW'(push_a) + SPW'(push_b) - SPW'(pop);
        end
    end
endmodule

// File: rtl/quicksort_ctrl.sv
// Quicksort sequencer: owns the array register and feeds (lo, hi) ranges to a
// Lomuto partition engine over a req/ack handshake until the range stack drains.
module quicksort_ctrl import qsort_pkg::*; #(
    parameter int ARR_WIDTH = ARR_WIDTH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IW        = idx_w(ARR_WIDTH),
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [ARR_WIDTH*DATA_W-1:0] array_in,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [ARR_WIDTH*DATA_W-1:0] sorted_out,
    output logic                        part_req,
    output logic [IW-1:0]               part_lo,
    output logic [IW-1:0]               part_hi,
    output logic [ARR_WIDTH*DATA_W-1:0] part_array,
    input  logic                        part_ack,
    input  logic [ARR_WIDTH*DATA_W-1:0] part_result,
    input  logic [IW-1:0]               part_idx
);
    localparam int AW = ARR_WIDTH * DATA_W;
    localparam int EW = entry_w(IW);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW:0] TWO = (IW + 1)'(2);

    state_t         state;
    logic [AW-1:0]  arr_q;
    logic [IW-1:0]  piv;
    logic [TW-1:0]  tmr;

    logic [IW:0]    lo_x, hi_x, p_x;
    logic [IW-1:0]  p_inc, p_dec;
    logic           bad_piv, push_r, push_l;
    logic           s_push_a, s_push_b, s_pop, s_clear, s_empty, s_full;
    logic [EW-1:0]  s_din_a, s_din_b, s_top;

    assign sorted_out = arr_q;
    assign part_array = arr_q;

    // Range arithmetic in IW+1 bits so p-1 / p+1 near the ends never wrap.
    assign lo_x    = {1'b0, part_lo};
    assign hi_x    = {1'b0, part_hi};
    assign p_x     = {1'b0, piv};
    assign p_inc   = piv + 1'b1;
    assign p_dec   = piv - 1'b1;
    assign bad_piv = (p_x < lo_x) || (p_x > hi_x);
    assign push_r  = !bad_piv && ((hi_x - p_x) >= TWO);
    assign push_l  = !bad_piv && ((p_x - lo_x) >= TWO);

    // Right goes in first so the left sub-range is popped next.
    assign s_push_a = (state == IDLE && start) || (state == CHECK && (push_r || push_l));
    assign s_push_b = (state == CHECK) && push_r && push_l;
    assign s_din_a  = (state == IDLE) ? {IW'(0), IW'(ARR_WIDTH - 1)}
                    : push_r ? {p_inc, part_hi} : {part_lo, p_dec};
    assign s_din_b  = {part_lo, p_dec};
    assign s_pop    = (state == POP) && !s_empty;
    assign s_clear  = (state == FAIL);

    qsort_range_stack #(.DEPTH(ARR_WIDTH), .EW(EW)) u_stack (
        .clock (clock),
        .reset (reset),
        .clear (s_clear),
        .push_a(s_push_a),
        .din_a (s_din_a),
        .push_b(s_push_b),
        .din_b (s_din_b),
        .pop   (s_pop),
        .top   (s_top),
        .empty (s_empty),
        .full  (s_full)
    );

    // Outputs are set on the edge entering a state, so done/error are high during FINISH/FAIL.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            part_req <= 1'b0;
            part_lo  <= '0;
            part_hi  <= '0;
            arr_q    <= '0;
            piv      <= '0;
            tmr      <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    arr_q <= array_in;
                    busy  <= 1'b1;
                    state <= POP;
                end
                POP: if (s_empty) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end else begin
                    {part_lo, part_hi} <= s_top;
                    state <= ISSUE;
                end
                ISSUE: begin
                    part_req <= 1'b1;
                    tmr      <= '0;
                    state    <= WAIT;
                end
                WAIT: if (part_ack) begin
                    arr_q    <= part_result;
                    piv      <= part_idx;
                    part_req <= 1'b0;
                    state    <= CHECK;
                end else if (tmr == TW'(TIMEOUT - 1)) begin
                    part_req <= 1'b0;
                    busy     <= 1'b0;
                    error    <= 1'b1;
                    state    <= FAIL;
                end else begin
                    tmr <= tmr + 1'b1;
                end
                CHECK: if (bad_piv || s_full) begin
                    busy  <= 1'b0;
                    error <= 1'b1;
                    state <= FAIL;
                end else begin
                    state <= POP;
                end
                FINISH:  state <= IDLE;
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/quicksort_ctrl.md
Name: quicksort_ctrl

Overview:
- Quicksort sequencer; the initiator that drives the Lomuto partition engine.
- Accepts a packed array from the host and keeps an explicit LIFO stack of (lo, hi) sub-ranges.
- Issues one partition request per range over a req/ack handshake, pushes the resulting sub-ranges, and returns the sorted array with a done pulse.
- Sits between the host interface and the partition engine. The controller owns the array register; the engine only transforms the copy it is given.

Parameters:
- ARR_WIDTH, 4: number of elements (≥2).
- DATA_W, 4: element width in bits.
- IW, $clog2(ARR_WIDTH) (min 1): index width.
- TIMEOUT, 16: max cycles to wait for part_ack before error.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  host request; sampled only in IDLE.
- array_in  in  ARR_WIDTH*DATA_W  unsorted array; element k at [k*DATA_W +: DATA_W].
- busy  out  1  high from start acceptance until done/error.
- done  out  1  one-cycle pulse, sort complete.
- error  out  1  one-cycle pulse: bad pivot index, stack overflow or timeout.
- sorted_out  out  ARR_WIDTH*DATA_W  array register; valid when done, held until next start.
- part_req  out  1  partition request, held until part_ack.
- part_lo  out  IW  range low index, stable while part_req.
- part_hi  out  IW  range high index, stable while part_req.
- part_array  out  ARR_WIDTH*DATA_W  array presented to engine (= sorted_out register).
- part_ack  in  1  engine result valid, single cycle.
- part_result  in  ARR_WIDTH*DATA_W  partitioned array.
- part_idx  in  IW  final pivot position.

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, error, part_req, part_lo, part_hi, stack pointer and timeout counter all 0; array register 0. Reset mid-operation abandons the sort with no done or error.
- States and transitions:
  - IDLE: on start=1, latch array_in, push (0, ARR_WIDTH-1), busy=1, go to POP. start in any other state is ignored.
  - POP: if stack empty, go to FINISH. Else pop top into lo/hi and go to ISSUE.
  - ISSUE: assert part_req with part_lo/part_hi; clear timeout counter; go to WAIT.
  - WAIT: part_req held, counter increments each cycle.
    - part_ack=1: capture part_result into the array register, deassert part_req, go to CHECK.
    - Counter reaches TIMEOUT-1 without ack: go to FAIL.
  - CHECK:
    - part_idx < lo or part_idx > hi: go to FAIL.
    - Otherwise push in the same cycle (up to two pushes): right (p+1, hi) if hi-p ≥ 2, then left (lo, p-1) if p-lo ≥ 2. Left is popped first. Go to POP.
    - Size-1 and size-0 sub-ranges are never pushed. Compute differences in IW+1 bits; no wrap.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
  - FAIL: error=1 for one cycle, busy=0, clear stack, go to IDLE. sorted_out holds the partial array.
- Stack: depth ARR_WIDTH entries of 2*IW bits. A push when full → FAIL (overflow; unreachable with a correct engine).
- part_ack outside WAIT is ignored.
- Latency: ARR_WIDTH=4 already sorted = 3 requests; each request costs POP+ISSUE+WAIT(≥1)+CHECK.

Decomposition:
- Shared package qsort_pkg: state localparams (IDLE, POP, ISSUE, WAIT, CHECK, FINISH, FAIL), DATA_W/IW defaults, range-entry pack/unpack widths. The partition engine uses the same package.
- One sub-module: qsort_range_stack (sync LIFO; dual-push, single-pop, full/empty flags).

Test Plan (bench has a behavioural Lomuto engine, ack 2 cycles after req unless stated):
- Reset: hold reset=0 with random inputs → all outputs 0; release, idle 5 cycles → busy=0, part_req=0.
- Unsorted: array_in=16'h0213 (e0=3,e1=1,e2=2,e3=0), start → requests (0,3), (1,3), (1,2) in order; sorted_out=16'h3210; done one cycle; error=0.
- Already sorted: array_in=16'h3210 → requests (0,3), (0,2), (0,1); sorted_out=16'h3210; done.
- Bad pivot: engine returns part_idx=3 for range (1,2) → error pulse, busy=0, no done; next start sorts normally.
- Timeout: engine never acks, TIMEOUT=16 → error exactly 16 cycles after part_req rises; part_req drops.
- Robustness: start pulses during WAIT ignored. Async reset asserted mid-WAIT → outputs 0 immediately; a fresh start then completes with the correct result.
